instruction_memory_loadable: RTL and testbench

Parametrised, loadable instruction memory for the ARM core's fetch stage. It answers fetch requests with a registered one-cycle read and a valid handshake. A streaming load port lets a testbench or boot controller write a program image at run time. Unloaded locations read as NOP, and out-of-range or misaligned fetches optionally raise a fault.

---
 rtl/instruction_memory_loadable.sv | 114 +++++++++++
 tb/tb_instruction_memory_loadable.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loadable.sv
// rtl/instruction_memory_loadable.sv - loadable instruction memory with registered fetch port; optional IMEM_BOUNDS_CHECK_EN fault checking
module instruction_memory_loadable #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  output logic                     fetch_ready,
  output logic [31:0]              instruction,
  output logic                     instr_valid,
  output logic                     fault,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [31:0]              load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     load_done,
  output logic [$clog2(DEPTH):0]   load_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Power-up contents; reset never touches the array.
  logic [31:0] mem [DEPTH] = '{default: NOP_WORD};

  logic [AW-1:0] wptr;
  logic [AW-1:0] fetch_idx;
  logic          fetch_acc;
  logic          fetch_bad;
  logic          wr_en;
  logic          wr_at_end;
  logic          load_exit;

  assign fetch_ready = (state_q == RUN);
  assign load_ready  = (state_q == LOAD);
  assign fetch_acc   = fetch_req && fetch_ready;
  assign fetch_idx   = fetch_addr[AW+1:2];
  assign wr_en       = load_valid && load_ready;
  assign wr_at_end   = (wptr == AW'(DEPTH - 1));
  assign load_exit   = wr_en && (load_last || wr_at_end);

`ifdef IMEM_BOUNDS_CHECK_EN
  assign fetch_bad = (|fetch_addr[31:AW+2]) || (|fetch_addr[1:0]);
`else
  // Index wraps modulo DEPTH; upper and byte-offset bits play no part.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};
  assign fetch_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Next state: RUN enters LOAD on load_start; LOAD leaves on last or final-slot word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (load_start) state_d = LOAD;
      LOAD:    if (load_exit)  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Load write pointer and word counter; pointer saturates at the last slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      load_count <= '0;
    end else if (state_q == RUN && load_start) begin
      wptr       <= '0;
      load_count <= '0;
    end else if (wr_en) begin
      if (!wr_at_end) wptr <= wptr + 1'b1;
      load_count <= load_count + 1'b1;
    end
  end

  // Array write port for the load stream.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= load_data;
  end

  // Registered fetch result; instruction holds between fetches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      instr_valid <= fetch_acc;
      fault       <= fetch_acc && fetch_bad;
      if (fetch_acc) instruction <= fetch_bad ? NOP_WORD : mem[fetch_idx];
    end
  end

  // One-cycle completion pulse following the final accepted load word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) load_done <= 1'b0;
    else      load_done <= load_exit;
  end

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// tb/tb_instruction_memory_loadable.sv - directed self-checking bench for instruction_memory_loadable
module tb_instruction_memory_loadable;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        fault;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic [6:0]  load_count;

  int n_assert = 0;
  int n_fail   = 0;

  instruction_memory_loadable #(.DEPTH(64), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instruction(instruction), .instr_valid(instr_valid), .fault(fault),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    #12;
    chk("rst_instr", instruction, NOP);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    rst = 1'b1;
    step();

    // Fetch of unloaded word 0.
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0;
    chk("f0_valid", 32'(instr_valid), 32'd1);
    chk("f0_instr", instruction, NOP);
    chk("f0_fault", 32'(fault), 32'd0);
    step();
    chk("idle_valid", 32'(instr_valid), 32'd0);
    chk("idle_hold", instruction, NOP);

    // Load interrupted by reset after two words.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("ld1_ready", 32'(load_ready), 32'd1);
    chk("ld1_fetch_ready", 32'(fetch_ready), 32'd0);
    load_valid = 1'b1; load_data = 32'h11111111;
    step();
    load_data = 32'h22222222;
    step();
    load_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_count", 32'(load_count), 32'd0);
    chk("abort_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("abort_load_ready", 32'(load_ready), 32'd0);
    #2 rst = 1'b1;
    step();
    fetch_req = 1'b1; fetch_addr = 32'h4;
    step();
    chk("abort_a4", instruction, 32'h22222222);
    fetch_addr = 32'h8;
    step();
    fetch_req = 1'b0;
    chk("abort_a8", instruction, NOP);

    // Three-word program.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 32'hE3A01A01;
    step();
    load_data = 32'hE3A00014;
    step();
    chk("p3_no_done_early", 32'(load_done), 32'd0);
    load_data = 32'hE0923002; load_last = 1'b1;
    step();
    load_valid = 1'b0; load_last = 1'b0;
    chk("p3_done", 32'(load_done), 32'd1);
    chk("p3_count", 32'(load_count), 32'd3);
    chk("p3_ready_low", 32'(load_ready), 32'd0);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    chk("p3_done_pulse", 32'(load_done), 32'd0);
    chk("p3_w0", instruction, 32'hE3A01A01);
    chk("p3_v0", 32'(instr_valid), 32'd1);
    fetch_addr = 32'h4;
    step();
    chk("p3_w1", instruction, 32'hE3A00014);
    chk("p3_v1", 32'(instr_valid), 32'd1);
    fetch_addr = 32'h8;
    step();
    fetch_req = 1'b0;
    chk("p3_w2", instruction, 32'hE0923002);
    chk("p3_v2", 32'(instr_valid), 32'd1);

    // Fetch and load_start in the same cycle.
    fetch_req = 1'b1; fetch_addr = 32'h4; load_start = 1'b1;
    step();
    load_start = 1'b0; fetch_addr = 32'h0;
    chk("same_valid", 32'(instr_valid), 32'd1);
    chk("same_instr", instruction, 32'hE3A00014);
    chk("same_load_ready", 32'(load_ready), 32'd1);
    step();
    fetch_req = 1'b0;
    chk("load_ignores_fetch", 32'(instr_valid), 32'd0);
    load_valid = 1'b1; load_last = 1'b1; load_data = 32'hE3A01A01;
    step();
    load_valid = 1'b0; load_last = 1'b0;
    chk("one_done", 32'(load_done), 32'd1);
    chk("one_count", 32'(load_count), 32'd1);

    // Overlong image: 70 words, no load_last.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (i >= 64) chk($sformatf("ovf_ready_%0d", i), 32'(load_ready), 32'd0);
      load_valid = 1'b1; load_data = 32'hC0000000 + 32'(i);
      step();
      if (i == 62) chk("ovf_no_done_early", 32'(load_done), 32'd0);
      if (i == 63) begin
        chk("ovf_done", 32'(load_done), 32'd1);
        chk("ovf_count", 32'(load_count), 32'd64);
        chk("ovf_ready_drop", 32'(load_ready), 32'd0);
      end
    end
    load_valid = 1'b0;
    chk("ovf_count_final", 32'(load_count), 32'd64);
    fetch_req = 1'b1; fetch_addr = 32'hFC;
    step();
    chk("ovf_w63", instruction, 32'hC000003F);
    fetch_addr = 32'h100;
    step();
`ifdef IMEM_BOUNDS_CHECK_EN
    chk("oob_instr", instruction, NOP);
    chk("oob_fault", 32'(fault), 32'd1);
`else
    chk("wrap_instr", instruction, 32'hC0000000);
    chk("wrap_fault", 32'(fault), 32'd0);
`endif
    fetch_addr = 32'h6;
    step();
    fetch_req = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
    chk("mis_instr", instruction, NOP);
    chk("mis_fault", 32'(fault), 32'd1);
`else
    chk("mis_instr", instruction, 32'hC0000001);
    chk("mis_fault", 32'(fault), 32'd0);
`endif
    step();
    chk("fault_clear", 32'(fault), 32'd0);
    chk("valid_clear", 32'(instr_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
